// File: rtl/xdist_age_ctrl.sv
// Learn/aging controller for port A of the XDist forwarding table RAM.
// Ports: clk_a/rst_n (sync, active-low); ram_init_done gates startup;
//   learn_vld/learn_rdy/learn_addr/learn_port: learn request handshake;
//   aging_tick: sweep request pulse;
//   ram_wren/ram_addr/ram_wrdata/ram_rddata: RAM port A;
//   move_pulse/new_pulse: learn outcome; sweep_busy: sweep active;
//   aged_cnt: saturating count of expired entries; tick_ovf: sticky drop flag.
module xdist_age_ctrl #(
    parameter int                DEPTH_W = 10,
    parameter int                PORT_W  = 4,
    parameter int                AGE_W   = 3,
    parameter logic [AGE_W-1:0]  AGE_MAX = 3'd7,
    parameter int                WIDTH_W = 1 + AGE_W + PORT_W
) (
    input  logic               clk_a,
    input  logic               rst_n,
    input  logic               ram_init_done,
    input  logic               learn_vld,
    output logic               learn_rdy,
    input  logic [DEPTH_W-1:0] learn_addr,
    input  logic [PORT_W-1:0]  learn_port,
    input  logic               aging_tick,
    output logic               ram_wren,
    output logic [DEPTH_W-1:0] ram_addr,
    output logic [WIDTH_W-1:0] ram_wrdata,
    input  logic [WIDTH_W-1:0] ram_rddata,
    output logic               move_pulse,
    output logic               new_pulse,
    output logic               sweep_busy,
    output logic [15:0]        aged_cnt,
    output logic               tick_ovf
);

    typedef enum logic [2:0] {
        WAIT_INIT,
        IDLE,
        LRN_RD,
        LRN_WR,
        AGE_RD,
        AGE_WR
    } state_t;

    localparam logic [DEPTH_W-1:0] PTR_LAST = '1;

    state_t             state_q;
    logic [DEPTH_W-1:0] ptr_q;
    logic [DEPTH_W-1:0] laddr_q;
    logic [PORT_W-1:0]  lport_q;
    logic               pend_q;
    logic               busy_q;
    logic               new_q;
    logic               move_q;
    logic [15:0]        aged_q;
    logic               ovf_q;

    logic               rd_vld;
    logic [AGE_W-1:0]   rd_age;
    logic [PORT_W-1:0]  rd_port;
    logic [AGE_W-1:0]   age_dec;
    logic               hs;

    assign rd_vld  = ram_rddata[WIDTH_W-1];
    assign rd_age  = ram_rddata[WIDTH_W-2:PORT_W];
    assign rd_port = ram_rddata[PORT_W-1:0];
    assign age_dec = rd_age - AGE_W'(1);

    // Learns are taken in IDLE and between sweep entries.
    assign learn_rdy = (state_q == IDLE) || (state_q == AGE_WR);
    assign hs        = learn_vld && learn_rdy;

    assign move_pulse = move_q;
    assign new_pulse  = new_q;
    assign sweep_busy = busy_q;
    assign aged_cnt   = aged_q;
    assign tick_ovf   = ovf_q;

    always_ff @(posedge clk_a) begin
        if (!rst_n) begin
            state_q <= WAIT_INIT;
            ptr_q   <= '0;
            laddr_q <= '0;
            lport_q <= '0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
            new_q   <= 1'b0;
            move_q  <= 1'b0;
            aged_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            new_q  <= 1'b0;
            move_q <= 1'b0;
            if (aging_tick && state_q != WAIT_INIT) begin
                if (pend_q) ovf_q  <= 1'b1;
                else        pend_q <= 1'b1;
            end
            if (hs) begin
                laddr_q <= learn_addr;
                lport_q <= learn_port;
            end
            unique case (state_q)
                WAIT_INIT: begin
                    if (ram_init_done) state_q <= IDLE;
                end
                IDLE: begin
                    if (hs) begin
                        state_q <= LRN_RD;
                    end else if (pend_q) begin
                        // pend_q is set here, so a same-cycle tick
                        // counts as overflow above and is dropped.
                        pend_q  <= 1'b0;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= AGE_RD;
                    end
                end
                LRN_RD: state_q <= LRN_WR;
                LRN_WR: begin
                    new_q   <= !rd_vld;
                    move_q  <= rd_vld && (rd_port != lport_q);
                    state_q <= busy_q ? AGE_RD : IDLE;
                end
                AGE_RD: state_q <= AGE_WR;
                AGE_WR: begin
                    if (rd_vld && rd_age == '0 && aged_q != 16'hFFFF)
                        aged_q <= aged_q + 16'd1;
                    if (ptr_q == PTR_LAST) busy_q <= 1'b0;
                    else                   ptr_q  <= ptr_q + 1'b1;
                    if (hs)                     state_q <= LRN_RD;
                    else if (ptr_q == PTR_LAST) state_q <= IDLE;
                    else                        state_q <= AGE_RD;
                end
                default: state_q <= WAIT_INIT;
            endcase
        end
    end

    always_comb begin
        ram_wren   = 1'b0;
        ram_addr   = '0;
        ram_wrdata = '0;
        unique case (state_q)
            LRN_RD: ram_addr = laddr_q;
            LRN_WR: begin
                ram_addr   = laddr_q;
                ram_wren   = 1'b1;
                ram_wrdata = {1'b1, AGE_MAX, lport_q};
            end
            AGE_RD: ram_addr = ptr_q;
            AGE_WR: begin
                ram_addr = ptr_q;
                ram_wren = rd_vld;
                // Expired entries are written back as all-zeros.
                if (rd_vld && rd_age != '0)
                    ram_wrdata = {1'b1, age_dec, rd_port};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_xdist_age_ctrl.sv
// Bench for xdist_age_ctrl with a behavioural port-A RAM model.
// Directed learn vectors plus sweep, interleave, overflow and reset sequences.
module tb_xdist_age_ctrl;

    logic        clk_a = 1'b0;
    logic        rst_n;
    logic        ram_init_done;
    logic        learn_vld;
    logic        learn_rdy;
    logic [9:0]  learn_addr;
    logic [3:0]  learn_port;
    logic        aging_tick;
    logic        ram_wren;
    logic [9:0]  ram_addr;
    logic [7:0]  ram_wrdata;
    logic [7:0]  ram_rddata;
    logic        move_pulse;
    logic        new_pulse;
    logic        sweep_busy;
    logic [15:0] aged_cnt;
    logic        tick_ovf;

    logic [7:0]  mem [0:1023];

    int errs   = 0;
    int checks = 0;

    always #5 clk_a = ~clk_a;

    xdist_age_ctrl dut (
        .clk_a        (clk_a),
        .rst_n        (rst_n),
        .ram_init_done(ram_init_done),
        .learn_vld    (learn_vld),
        .learn_rdy    (learn_rdy),
        .learn_addr   (learn_addr),
        .learn_port   (learn_port),
        .aging_tick   (aging_tick),
        .ram_wren     (ram_wren),
        .ram_addr     (ram_addr),
        .ram_wrdata   (ram_wrdata),
        .ram_rddata   (ram_rddata),
        .move_pulse   (move_pulse),
        .new_pulse    (new_pulse),
        .sweep_busy   (sweep_busy),
        .aged_cnt     (aged_cnt),
        .tick_ovf     (tick_ovf)
    );

    // Port-A RAM: 1-cycle read, write bypass, cleared on reset.
    always @(posedge clk_a) begin
        if (!rst_n) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
            ram_rddata <= '0;
        end else if (ram_wren) begin
            mem[ram_addr] <= ram_wrdata;
            ram_rddata    <= ram_wrdata;
        end else begin
            ram_rddata <= mem[ram_addr];
        end
    end

    typedef struct {
        logic [9:0] addr;
        logic [3:0] port;
        logic       exp_new;
        logic       exp_move;
        logic [7:0] exp_word;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        aging_tick = 1'b1;
        @(negedge clk_a);
        aging_tick = 1'b0;
    endtask

    task automatic wait_busy(input logic lvl, input int lim,
                             output int n);
        n = 0;
        while (sweep_busy !== lvl && n < lim) begin
            @(negedge clk_a);
            n++;
        end
        chk("busy_wait", 32'(sweep_busy), 32'(lvl));
    endtask

    task automatic do_learn(input logic [9:0] a, input logic [3:0] p);
        int n;
        learn_vld  = 1'b1;
        learn_addr = a;
        learn_port = p;
        n = 0;
        while (!learn_rdy && n < 50) begin
            @(negedge clk_a);
            n++;
        end
        chk("learn_rdy_wait", 32'(learn_rdy), 32'd1);
        @(negedge clk_a);
        learn_vld = 1'b0;
    endtask

    task automatic sweep(input logic chk_len);
        int n;
        tick();
        wait_busy(1'b1, 10, n);
        wait_busy(1'b0, 3000, n);
        if (chk_len) chk("sweep_len", 32'(n), 32'd2048);
    endtask

    initial begin
        int  n;
        logic bad;

        vecs[0] = '{10'd5,    4'd3,  1'b1, 1'b0, 8'hF3};
        vecs[1] = '{10'd5,    4'd3,  1'b0, 1'b0, 8'hF3};
        vecs[2] = '{10'd5,    4'd9,  1'b0, 1'b1, 8'hF9};
        vecs[3] = '{10'd7,    4'd3,  1'b1, 1'b0, 8'hF3};
        vecs[4] = '{10'd0,    4'd0,  1'b1, 1'b0, 8'hF0};
        vecs[5] = '{10'd1023, 4'd15, 1'b1, 1'b0, 8'hFF};
        vecs[6] = '{10'd0,    4'd1,  1'b0, 1'b1, 8'hF1};

        rst_n         = 1'b0;
        ram_init_done = 1'b0;
        learn_vld     = 1'b0;
        learn_addr    = '0;
        learn_port    = '0;
        aging_tick    = 1'b0;
        repeat (3) @(negedge clk_a);
        chk("rst_rdy",   32'(learn_rdy),  32'd0);
        chk("rst_wren",  32'(ram_wren),   32'd0);
        chk("rst_addr",  32'(ram_addr),   32'd0);
        chk("rst_wdata", 32'(ram_wrdata), 32'd0);
        chk("rst_busy",  32'(sweep_busy), 32'd0);
        chk("rst_aged",  32'(aged_cnt),   32'd0);
        chk("rst_misc",  32'({tick_ovf, new_pulse, move_pulse}), 32'd0);

        rst_n     = 1'b1;
        learn_vld = 1'b1;
        bad       = 1'b0;
        for (int i = 0; i < 50; i++) begin
            aging_tick = (i % 10 == 3);
            @(negedge clk_a);
            if (learn_rdy || ram_wren) bad = 1'b1;
        end
        chk("init_gate", 32'(bad), 32'd0);
        learn_vld     = 1'b0;
        aging_tick    = 1'b0;
        ram_init_done = 1'b1;
        n = 0;
        while (!learn_rdy && n < 2) begin
            @(negedge clk_a);
            n++;
        end
        chk("init_rdy", 32'(learn_rdy), 32'd1);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_a);
            if (sweep_busy) bad = 1'b1;
        end
        chk("no_tick_latched", 32'(bad), 32'd0);

        for (int i = 0; i < 7; i++) begin
            do_learn(vecs[i].addr, vecs[i].port);
            @(negedge clk_a);
            @(negedge clk_a);
            chk("vec_new",  32'(new_pulse),  32'(vecs[i].exp_new));
            chk("vec_move", 32'(move_pulse), 32'(vecs[i].exp_move));
            chk("vec_word", 32'(mem[vecs[i].addr]), 32'(vecs[i].exp_word));
        end

        for (int s = 1; s <= 7; s++) sweep(s == 1);
        chk("age7_addr7", 32'(mem[7]), 32'h83);
        chk("age7_addr5", 32'(mem[5]), 32'h89);
        chk("age7_cnt",   32'(aged_cnt), 32'd0);
        sweep(1'b1);
        chk("age8_addr7", 32'(mem[7]), 32'h00);
        chk("age8_addr0", 32'(mem[0]), 32'h00);
        chk("age8_cnt",   32'(aged_cnt), 32'd4);
        chk("no_ovf",     32'(tick_ovf), 32'd0);

        tick();
        wait_busy(1'b1, 10, n);
        n = 0;
        while (ram_addr != 10'd10 && n < 100) begin
            @(negedge clk_a);
            n++;
        end
        chk("ptr10_seen", 32'(ram_addr), 32'd10);
        do_learn(10'd1000, 4'd6);
        chk("il_rd", 32'({ram_wren, ram_addr}), 32'({1'b0, 10'd1000}));
        @(negedge clk_a);
        chk("il_wr", 32'({ram_wren, ram_addr, ram_wrdata}),
            32'({1'b1, 10'd1000, 8'hF6}));
        @(negedge clk_a);
        chk("il_new",    32'(new_pulse), 32'd1);
        chk("il_resume", 32'({ram_wren, ram_addr}), 32'({1'b0, 10'd11}));
        wait_busy(1'b0, 3000, n);
        chk("il_word", 32'(mem[1000]), 32'hE6);

        tick();
        wait_busy(1'b1, 10, n);
        repeat (100) @(negedge clk_a);
        tick();
        repeat (100) @(negedge clk_a);
        tick();
        chk("ovf_set", 32'(tick_ovf), 32'd1);
        wait_busy(1'b0, 3000, n);
        wait_busy(1'b1, 10, n);
        wait_busy(1'b0, 3000, n);
        chk("ovf_len", 32'(n), 32'd2048);
        bad = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_a);
            if (sweep_busy) bad = 1'b1;
        end
        chk("ovf_one_extra", 32'(bad), 32'd0);
        chk("ovf_word", 32'(mem[1000]), 32'hC6);

        tick();
        wait_busy(1'b1, 10, n);
        n = 0;
        while (ram_addr != 10'd300 && n < 1000) begin
            @(negedge clk_a);
            n++;
        end
        chk("ptr300_seen", 32'(ram_addr), 32'd300);
        rst_n         = 1'b0;
        ram_init_done = 1'b0;
        @(negedge clk_a);
        chk("mrst_ctl", 32'({learn_rdy, ram_wren, sweep_busy, tick_ovf,
                             new_pulse, move_pulse}), 32'd0);
        chk("mrst_ram", 32'({ram_addr, ram_wrdata}), 32'd0);
        chk("mrst_aged", 32'(aged_cnt), 32'd0);
        rst_n     = 1'b1;
        learn_vld = 1'b1;
        bad       = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_a);
            if (learn_rdy) bad = 1'b1;
        end
        chk("mrst_gate", 32'(bad), 32'd0);
        learn_vld     = 1'b0;
        ram_init_done = 1'b1;
        n = 0;
        while (!learn_rdy && n < 2) begin
            @(negedge clk_a);
            n++;
        end
        chk("mrst_rdy", 32'(learn_rdy), 32'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
